// File: rtl/sram_stream_reader_pkg.sv
// Shared definitions for the SRAM port-B stream reader: state encoding and default widths.
package sram_stream_pkg;

    localparam int unsigned DEF_ADDR_WIDTH  = 9;
    localparam int unsigned DEF_DATA_WIDTH  = 32;
    localparam int unsigned DEF_QUEUE_DEPTH = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/sram_stream_reader_if.sv
// Valid/ready word stream between the reader and its consumer.
// SRAM_STREAM_LAST_EN adds streamLast, marking the final word of a transfer.
interface sram_stream_reader_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  streamValid;
    logic [DATA_WIDTH-1:0] streamData;
    logic                  streamReady;
`ifdef SRAM_STREAM_LAST_EN
    logic                  streamLast;

    modport master (output streamValid, output streamData, output streamLast, input streamReady);
    modport slave  (input streamValid, input streamData, input streamLast, output streamReady);
`else
    modport master (output streamValid, output streamData, input streamReady);
    modport slave  (input streamValid, input streamData, output streamReady);
`endif
endinterface

// File: rtl/sram_stream_reader_queue.sv
// Small synchronous FIFO holding words returned by the SRAM until the consumer takes them.
// Push and pop in the same cycle are allowed even when full; reset flushes all entries.
module stream_queue #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 3
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           push_i,
    input  logic [DATA_WIDTH-1:0]          push_data_i,
    input  logic                           pop_i,
    output logic [DATA_WIDTH-1:0]          head_o,
    output logic                           valid_o,
    output logic [$clog2(DEPTH+1)-1:0]     occupancy_o
);
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [OCC_W-1:0]      count_q;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Entry storage needs no reset: the head is masked to zero while empty.
    always_ff @(posedge clock) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop_i) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + OCC_W'(1);
                2'b01:   count_q <= count_q - OCC_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign valid_o     = (count_q != '0);
    assign head_o      = valid_o ? mem_q[rd_ptr_q] : '0;
    assign occupancy_o = count_q;

endmodule

// File: rtl/sram_stream_reader.sv
// Walks SRAM port B from a start address for a word count and streams the words out.
// Optional SRAM_STREAM_LAST_EN drives stream.streamLast on the final word of a transfer.
module sram_stream_reader
    import sram_stream_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int unsigned QUEUE_DEPTH = DEF_QUEUE_DEPTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] startAddress,
    input  logic [ADDR_WIDTH:0]   wordCount,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] sramAddress,
    input  logic [DATA_WIDTH-1:0] sramData,
    sram_stream_reader_if.master  stream
);
    localparam int unsigned OCC_W = $clog2(QUEUE_DEPTH + 1);
    localparam int unsigned SUM_W = OCC_W + 1;
    localparam int unsigned CNT_W = ADDR_WIDTH + 1;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]      issue_left_q, issue_left_d;
    logic [CNT_W-1:0]      accept_left_q, accept_left_d;
    logic                  in_flight_q, in_flight_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic [OCC_W-1:0]      occupancy;
    logic                  q_valid;
    logic [DATA_WIDTH-1:0] q_head;
    logic                  issue_c;
    logic                  pop_c;

    // A read may only issue when the queue can absorb it plus any word still in flight.
    assign issue_c = (state_q == READ) && (issue_left_q != '0) &&
                     ((SUM_W'(occupancy) + SUM_W'(in_flight_q)) < SUM_W'(QUEUE_DEPTH));
    assign pop_c   = q_valid & stream.streamReady;

    stream_queue #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (QUEUE_DEPTH)
    ) u_queue (
        .clock       (clock),
        .reset       (reset),
        .push_i      (in_flight_q),
        .push_data_i (sramData),
        .pop_i       (pop_c),
        .head_o      (q_head),
        .valid_o     (q_valid),
        .occupancy_o (occupancy)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            issue_left_q  <= '0;
            accept_left_q <= '0;
            in_flight_q   <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            issue_left_q  <= issue_left_d;
            accept_left_q <= accept_left_d;
            in_flight_q   <= in_flight_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        issue_left_d  = issue_left_q;
        accept_left_d = accept_left_q;
        in_flight_d   = issue_c;

        if (pop_c) begin
            accept_left_d = accept_left_q - CNT_W'(1);
        end
        if (issue_c) begin
            addr_d       = addr_q + ADDR_WIDTH'(1);
            issue_left_d = issue_left_q - CNT_W'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (wordCount != '0) begin
                        addr_d        = startAddress;
                        issue_left_d  = wordCount;
                        accept_left_d = wordCount;
                        state_d       = READ;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            READ: begin
                if (issue_c && (issue_left_q == CNT_W'(1))) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop_c && (accept_left_q == CNT_W'(1))) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    assign sramAddress       = addr_q;
    assign busy              = busy_q;
    assign done              = done_q;
    assign stream.streamValid = q_valid;
    assign stream.streamData  = q_head;
`ifdef SRAM_STREAM_LAST_EN
    // Only the final word can be at the head while one acceptance remains.
    assign stream.streamLast  = q_valid && (accept_left_q == CNT_W'(1));
`endif

endmodule
